// File: rtl/vga_scaled_timing_gen.sv
// vga_scaled_timing_gen
//   Parametrised VGA timing generator with framebuffer scan and integer pixel
//   replication. Raw h/v counters produce sync, blanking and data-enable
//   timing. Incremental sub-counters derive the framebuffer read address
//   without a divider or multiplier. A short flag pipeline delays sync, DE
//   and the first-pixel marker so that they leave the block in step with the
//   colour read back from the framebuffer.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   pix_ce       pixel-tick enable; all timing advances only when high
//   enable       scan enable; low holds the block idle at reset levels
//   mem_addr     framebuffer read address (0 outside the active region)
//   mem_rdata    {red,green,blue} returned MEM_LAT ticks after the address
//   red/green/blue  colour outputs, forced to 0 while de is low
//   hsync/vsync  pipelined syncs, active level set by HS_POL / VS_POL
//   de           pipelined data enable
//   frame_start  one-clk pulse when output pixel (0,0) is emitted
//   h_count/v_count  raw scan counters, ahead of the output pipeline
module vga_scaled_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int SCALE    = 4,
  parameter int CW       = 4,
  parameter int MEM_LAT  = 1,
  parameter int ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_ce,
  input  logic              enable,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [3*CW-1:0]   mem_rdata,
  output logic [CW-1:0]     red,
  output logic [CW-1:0]     green,
  output logic [CW-1:0]     blue,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              frame_start,
  output logic [9:0]        h_count,
  output logic [9:0]        v_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int SRC_W   = H_ACTIVE / SCALE;
  localparam int SRC_H   = V_ACTIVE / SCALE;
  localparam int PIPE    = MEM_LAT + 1;
  localparam int SUB_W   = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(SCALE - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SRC_W);

  localparam logic HS_IDLE = (HS_POL == 0) ? 1'b1 : 1'b0;
  localparam logic VS_IDLE = (VS_POL == 0) ? 1'b1 : 1'b0;

  // Reject modes that cannot be scanned exactly or addressed completely.
  generate
    if (H_ACTIVE % SCALE != 0) begin : g_bad_h_scale
      $error("H_ACTIVE must be a multiple of SCALE");
    end
    if (V_ACTIVE % SCALE != 0) begin : g_bad_v_scale
      $error("V_ACTIVE must be a multiple of SCALE");
    end
    if (longint'(SRC_W) * longint'(SRC_H) > (longint'(1) << ADDR_W)) begin : g_bad_addr
      $error("source image does not fit in ADDR_W address bits");
    end
    if (MEM_LAT < 1) begin : g_bad_lat
      $error("MEM_LAT must be at least 1");
    end
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("line or frame total exceeds the 10-bit counters");
    end
  endgenerate

  logic              h_act;
  logic              v_act;
  logic              raw_de;
  logic              raw_hs;
  logic              raw_vs;
  logic              raw_first;
  logic [SUB_W-1:0]  x_sub;
  logic [SUB_W-1:0]  y_sub;
  logic [ADDR_W-1:0] src_x;
  logic [ADDR_W-1:0] row_base;
  logic [PIPE-1:0]   hs_pipe;
  logic [PIPE-1:0]   vs_pipe;
  logic [PIPE-1:0]   de_pipe;
  logic [PIPE-1:0]   first_pipe;

  assign h_act     = (h_count < H_ACT);
  assign v_act     = (v_count < V_ACT);
  assign raw_de    = h_act && v_act;
  assign raw_hs    = (h_count >= HS_START) && (h_count < HS_END);
  assign raw_vs    = (v_count >= VS_START) && (v_count < VS_END);
  assign raw_first = (h_count == 10'd0) && (v_count == 10'd0);

  // Scan counters and address generation. x_sub/y_sub count replicated
  // copies of a source pixel; src_x and row_base step once per SCALE copies,
  // so the address is row_base + src_x without any division. src_x only
  // moves inside the active part of a line and row_base only across active
  // lines, and both restart at the line / frame wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_count  <= '0;
      v_count  <= '0;
      x_sub    <= '0;
      y_sub    <= '0;
      src_x    <= '0;
      row_base <= '0;
      mem_addr <= '0;
    end else if (!enable) begin
      h_count  <= '0;
      v_count  <= '0;
      x_sub    <= '0;
      y_sub    <= '0;
      src_x    <= '0;
      row_base <= '0;
      mem_addr <= '0;
    end else if (pix_ce) begin
      mem_addr <= raw_de ? (row_base + src_x) : '0;
      if (h_count == H_LAST) begin
        h_count <= '0;
        x_sub   <= '0;
        src_x   <= '0;
        if (v_count == V_LAST) begin
          v_count  <= '0;
          y_sub    <= '0;
          row_base <= '0;
        end else begin
          v_count <= v_count + 10'd1;
          if (v_act) begin
            if (y_sub == SUB_LAST) begin
              y_sub    <= '0;
              row_base <= row_base + ROW_STEP;
            end else begin
              y_sub <= y_sub + 1'b1;
            end
          end
        end
      end else begin
        h_count <= h_count + 10'd1;
        if (h_act) begin
          if (x_sub == SUB_LAST) begin
            x_sub <= '0;
            src_x <= src_x + 1'b1;
          end else begin
            x_sub <= x_sub + 1'b1;
          end
        end
      end
    end
  end

  // Flag delay line. Stage 0 loads on the same tick as mem_addr; together
  // with the output register below this matches the address register, the
  // MEM_LAT ticks of memory latency and the colour capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_pipe    <= '0;
      vs_pipe    <= '0;
      de_pipe    <= '0;
      first_pipe <= '0;
    end else if (!enable) begin
      hs_pipe    <= '0;
      vs_pipe    <= '0;
      de_pipe    <= '0;
      first_pipe <= '0;
    end else if (pix_ce) begin
      hs_pipe    <= {hs_pipe[PIPE-2:0], raw_hs};
      vs_pipe    <= {vs_pipe[PIPE-2:0], raw_vs};
      de_pipe    <= {de_pipe[PIPE-2:0], raw_de};
      first_pipe <= {first_pipe[PIPE-2:0], raw_first};
    end
  end

  // Output stage. Everything holds between ticks except frame_start, which
  // is dropped on the following clk so it stays a single-clk pulse even when
  // pix_ce is slower than clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= HS_IDLE;
      vsync       <= VS_IDLE;
      de          <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      frame_start <= 1'b0;
    end else if (!enable) begin
      hsync       <= HS_IDLE;
      vsync       <= VS_IDLE;
      de          <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_ce) begin
        hsync       <= hs_pipe[PIPE-1] ? ~HS_IDLE : HS_IDLE;
        vsync       <= vs_pipe[PIPE-1] ? ~VS_IDLE : VS_IDLE;
        de          <= de_pipe[PIPE-1];
        frame_start <= first_pipe[PIPE-1];
        if (de_pipe[PIPE-1]) begin
          {red, green, blue} <= mem_rdata;
        end else begin
          {red, green, blue} <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_scaled_timing_gen.sv
// tb_vga_scaled_timing_gen
//   Drives two instances of vga_scaled_timing_gen with shared stimulus:
//   instance A uses a small active-low-sync mode with SCALE=4, MEM_LAT=1;
//   instance B uses active-high syncs, SCALE=2, MEM_LAT=3. Each instance reads
//   a randomly filled framebuffer through a latency model. Expected outputs
//   come from an arithmetic reference model driven only by the number of
//   pixel ticks processed since the scan last restarted.
module tb_vga_scaled_timing_gen;

  // Instance A mode
  localparam int A_HA = 32, A_HF = 4, A_HS = 6, A_HB = 6;
  localparam int A_VA = 16, A_VF = 2, A_VS = 2, A_VB = 3;
  localparam int A_S  = 4,  A_LAT = 1, A_HP = 0, A_VP = 0;
  // Instance B mode
  localparam int B_HA = 32, B_HF = 2, B_HS = 4, B_HB = 4;
  localparam int B_VA = 12, B_VF = 1, B_VS = 2, B_VB = 2;
  localparam int B_S  = 2,  B_LAT = 3, B_HP = 1, B_VP = 1;

  typedef struct packed {
    logic [9:0]  h;
    logic [9:0]  v;
    logic [7:0]  addr;
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic [11:0] rgb;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic pix_ce;
  logic enable;

  logic [7:0]  addr_a, addr_b;
  logic [11:0] rdata_a, rdata_b;
  logic [3:0]  red_a, green_a, blue_a, red_b, green_b, blue_b;
  logic        hs_a, vs_a, de_a, fs_a, hs_b, vs_b, de_b, fs_b;
  logic [9:0]  hc_a, vc_a, hc_b, vc_b;

  logic [11:0] ram_a [256];
  logic [11:0] ram_b [256];
  logic [11:0] lat_a;
  logic [11:0] lat_b [3];

  int k;
  bit tick;
  int n_pass;
  int n_total;

  always #5 clk = ~clk;

  vga_scaled_timing_gen #(
    .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
    .HS_POL(A_HP), .VS_POL(A_VP), .SCALE(A_S), .CW(4),
    .MEM_LAT(A_LAT), .ADDR_W(8)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .enable(enable),
    .mem_addr(addr_a), .mem_rdata(rdata_a),
    .red(red_a), .green(green_a), .blue(blue_a),
    .hsync(hs_a), .vsync(vs_a), .de(de_a), .frame_start(fs_a),
    .h_count(hc_a), .v_count(vc_a)
  );

  vga_scaled_timing_gen #(
    .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .HS_POL(B_HP), .VS_POL(B_VP), .SCALE(B_S), .CW(4),
    .MEM_LAT(B_LAT), .ADDR_W(8)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .enable(enable),
    .mem_addr(addr_b), .mem_rdata(rdata_b),
    .red(red_b), .green(green_b), .blue(blue_b),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .frame_start(fs_b),
    .h_count(hc_b), .v_count(vc_b)
  );

  // Framebuffers: data appears MEM_LAT pixel ticks after the address and
  // holds until the next tick.
  always @(posedge clk) begin
    if (pix_ce) begin
      lat_a    <= ram_a[addr_a];
      lat_b[0] <= ram_b[addr_b];
      lat_b[1] <= lat_b[0];
      lat_b[2] <= lat_b[1];
    end
  end
  assign rdata_a = lat_a;
  assign rdata_b = lat_b[2];

  // Expected outputs after k ticks of scanning. Tick n scans raster position
  // n; its pixel reaches the outputs MEM_LAT+1 ticks later.
  function automatic exp_t model(input int inst, input int kk, input bit tk);
    int ha, hf, hsw, hb, va, vf, vsw, vb, s, lat, hp, vp;
    int ht, vt, n, j, hn, vn, a;
    exp_t e;
    if (inst == 0) begin
      ha = A_HA; hf = A_HF; hsw = A_HS; hb = A_HB;
      va = A_VA; vf = A_VF; vsw = A_VS; vb = A_VB;
      s = A_S; lat = A_LAT; hp = A_HP; vp = A_VP;
    end else begin
      ha = B_HA; hf = B_HF; hsw = B_HS; hb = B_HB;
      va = B_VA; vf = B_VF; vsw = B_VS; vb = B_VB;
      s = B_S; lat = B_LAT; hp = B_HP; vp = B_VP;
    end
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    e = '0;
    e.h = 10'(kk % ht);
    e.v = 10'((kk / ht) % vt);
    if (kk > 0) begin
      n = kk - 1;
      hn = n % ht;
      vn = (n / ht) % vt;
      if (hn < ha && vn < va) e.addr = 8'((vn / s) * (ha / s) + hn / s);
    end
    e.hs = (hp == 0);
    e.vs = (vp == 0);
    j = kk - 1 - (lat + 1);
    if (j >= 0) begin
      hn = j % ht;
      vn = (j / ht) % vt;
      e.hs = (hn >= ha + hf && hn < ha + hf + hsw) ? (hp != 0) : (hp == 0);
      e.vs = (vn >= va + vf && vn < va + vf + vsw) ? (vp != 0) : (vp == 0);
      e.de = (hn < ha && vn < va);
      if (e.de) begin
        a = (vn / s) * (ha / s) + hn / s;
        e.rgb = (inst == 0) ? ram_a[8'(a)] : ram_b[8'(a)];
      end
      e.fs = tk && hn == 0 && vn == 0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("[TB] FAIL %s observed=%0h expected=%0h (tick %0d)", tag, obs, expv, k);
    end
  endtask

  task automatic checkOutput();
    exp_t ea;
    exp_t eb;
    ea = model(0, k, tick);
    eb = model(1, k, tick);
    chk("A.h_count",     32'(hc_a), 32'(ea.h));
    chk("A.v_count",     32'(vc_a), 32'(ea.v));
    chk("A.mem_addr",    32'(addr_a), 32'(ea.addr));
    chk("A.hsync",       32'(hs_a), 32'(ea.hs));
    chk("A.vsync",       32'(vs_a), 32'(ea.vs));
    chk("A.de",          32'(de_a), 32'(ea.de));
    chk("A.frame_start", 32'(fs_a), 32'(ea.fs));
    chk("A.rgb",         32'({red_a, green_a, blue_a}), 32'(ea.rgb));
    chk("B.h_count",     32'(hc_b), 32'(eb.h));
    chk("B.v_count",     32'(vc_b), 32'(eb.v));
    chk("B.mem_addr",    32'(addr_b), 32'(eb.addr));
    chk("B.hsync",       32'(hs_b), 32'(eb.hs));
    chk("B.vsync",       32'(vs_b), 32'(eb.vs));
    chk("B.de",          32'(de_b), 32'(eb.de));
    chk("B.frame_start", 32'(fs_b), 32'(eb.fs));
    chk("B.rgb",         32'({red_b, green_b, blue_b}), 32'(eb.rgb));
  endtask

  // Called at a negedge: drive one clk of inputs, track the tick count the
  // scan should have reached, then compare at the following negedge.
  task automatic applyStimulus(input bit ce, input bit en);
    pix_ce = ce;
    enable = en;
    @(posedge clk);
    if (!rst_n || !en) k = 0;
    else if (ce) k++;
    tick = rst_n && en && ce;
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    int n;
    n_pass  = 0;
    n_total = 0;
    k       = 0;
    tick    = 1'b0;
    rst_n   = 1'b0;
    enable  = 1'b0;
    pix_ce  = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ram_a[i] = 12'($urandom);
      ram_b[i] = 12'($urandom);
    end
    $display("[TB] reset state");
    @(negedge clk);
    checkOutput();
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);

    $display("[TB] continuous pixel clock, more than two frames");
    rst_n = 1'b1;
    repeat (2400) applyStimulus(1'b1, 1'b1);

    $display("[TB] pix_ce every second clk");
    for (int i = 0; i < 2400; i++) applyStimulus(i % 2 == 0, 1'b1);

    $display("[TB] random pix_ce");
    repeat (1500) applyStimulus($urandom_range(0, 2) != 0, 1'b1);

    $display("[TB] asynchronous reset mid-frame");
    n = $urandom_range(50, 600);
    repeat (n) applyStimulus(1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    k = 0;
    tick = 1'b0;
    checkOutput();
    repeat (3) applyStimulus(1'b1, 1'b1);
    rst_n = 1'b1;
    repeat (400) applyStimulus(1'b1, 1'b1);

    $display("[TB] enable dropped mid-line and re-raised");
    n = $urandom_range(100, 700);
    repeat (n) applyStimulus(1'b1, 1'b1);
    n = $urandom_range(2, 8);
    repeat (n) applyStimulus($urandom_range(0, 1) != 0, 1'b0);
    repeat (1500) applyStimulus($urandom_range(0, 3) != 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
